// File: rtl/per_hs_pkg.sv
// Shared handshake codes and transmitter state encoding for the
// peripheral/CPU four-phase word link.
package per_hs_pkg;

    localparam logic [1:0] SEND_IDLE = 2'b00;
    localparam logic [1:0] SEND_WORD = 2'b01;
    localparam logic [1:0] SEND_LAST = 2'b10;

    localparam logic [1:0] ACK_IDLE  = 2'b00;
    localparam logic [1:0] ACK_OK    = 2'b01;
    localparam logic [1:0] ACK_RETRY = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        REL_OK,
        REL_RETRY
    } tx_state_t;

endpackage

// File: rtl/per_hs_sync.sv
// N-stage 2-bit synchronizer for an asynchronous handshake code.
// Reused unchanged on the CPU-side receiver.
module per_hs_sync #(
    parameter int STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] d_i,
    output logic [1:0] q_o
);

    logic [STAGES-1:0][1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/per_tx_handshake.sv
// Peripheral-side word transmitter: FIFO + four-phase send/ack FSM.
// Optional watchdog enabled by defining PER_TX_TIMEOUT_EN.
module per_tx_handshake
    import per_hs_pkg::*;
#(
    parameter int DATA_W         = 16,
    parameter int FIFO_DEPTH     = 4,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clkPER,
    input  logic              rstPER,
    input  logic [DATA_W-1:0] inWrData,
    input  logic              inWrLast,
    input  logic              inWrValid,
    output logic              outWrReady,
    output logic [1:0]        outSend,
    output logic [DATA_W-1:0] outData,
    input  logic [1:0]        inAck,
    output logic              outBusy,
    output logic              outErr
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    logic [DATA_W:0]    mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [CNT_W-1:0]   count_q;
    logic               push;
    logic               pop;

    tx_state_t          state_q;
    logic [1:0]         send_q;
    logic [DATA_W-1:0]  data_q;
    logic               last_q;
    logic [1:0]         ack_s;
    logic               ack_idle;

    per_hs_sync #(
        .STAGES(SYNC_STAGES)
    ) u_ack_sync (
        .clk  (clkPER),
        .rst_n(rstPER),
        .d_i  (inAck),
        .q_o  (ack_s)
    );

    // 11 is an illegal ack code and is read as idle
    assign ack_idle   = (ack_s == ACK_IDLE) || (ack_s == 2'b11);
    assign outWrReady = (count_q != FULL_CNT);
    assign push       = inWrValid && outWrReady;
    assign pop        = (state_q == IDLE) && (count_q != '0);

    always_ff @(posedge clkPER) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {inWrLast, inWrData};
        end
    end

    always_ff @(posedge clkPER or negedge rstPER) begin
        if (!rstPER) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

`ifdef PER_TX_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    logic [TMO_W-1:0] tmo_q;
    logic             err_q;
    logic             st_move;

    // Any state change restarts the watchdog for the new wait
    always_comb begin
        st_move = 1'b0;
        unique case (state_q)
            IDLE:    st_move = pop;
            REQ:     st_move = (ack_s == ACK_OK) || (ack_s == ACK_RETRY);
            default: st_move = ack_idle;
        endcase
    end

    assign outErr = err_q;
`else
    assign outErr = 1'b0;
`endif

    always_ff @(posedge clkPER or negedge rstPER) begin
        if (!rstPER) begin
            state_q <= IDLE;
            send_q  <= SEND_IDLE;
            data_q  <= '0;
            last_q  <= 1'b0;
`ifdef PER_TX_TIMEOUT_EN
            tmo_q   <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (pop) begin
                        data_q  <= mem_q[rd_ptr_q][DATA_W-1:0];
                        last_q  <= mem_q[rd_ptr_q][DATA_W];
                        send_q  <= mem_q[rd_ptr_q][DATA_W] ?
                                   SEND_LAST : SEND_WORD;
                        state_q <= REQ;
                    end
                end
                REQ: begin
                    if (ack_s == ACK_OK) begin
                        send_q  <= SEND_IDLE;
                        state_q <= REL_OK;
                    end else if (ack_s == ACK_RETRY) begin
                        send_q  <= SEND_IDLE;
                        state_q <= REL_RETRY;
                    end
                end
                REL_OK: begin
                    if (ack_idle) begin
                        state_q <= IDLE;
                    end
                end
                REL_RETRY: begin
                    if (ack_idle) begin
                        send_q  <= last_q ? SEND_LAST : SEND_WORD;
                        state_q <= REQ;
                    end
                end
                default: state_q <= IDLE;
            endcase
`ifdef PER_TX_TIMEOUT_EN
            if (state_q == IDLE) begin
                tmo_q <= '0;
            end else if (tmo_q == TMO_LAST) begin
                tmo_q   <= '0;
                send_q  <= SEND_IDLE;
                err_q   <= 1'b1;
                state_q <= IDLE;
            end else if (st_move) begin
                tmo_q <= '0;
            end else begin
                tmo_q <= tmo_q + 1'b1;
            end
`endif
        end
    end

    assign outSend = send_q;
    assign outData = data_q;
    assign outBusy = (state_q != IDLE) || (count_q != '0);

endmodule

// File: tb/tb_per_tx_handshake.sv
// Self-checking bench for per_tx_handshake: vector table, corner
// sequences and a randomized CPU-side agent with a scoreboard.
module tb_per_tx_handshake;

    localparam int DW    = 16;
    localparam int DEPTH = 4;
    localparam int SS    = 2;
    localparam int TMO   = 10;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [DW-1:0] wr_data;
    logic          wr_last;
    logic          wr_valid;
    logic          wr_ready;
    logic [1:0]    send;
    logic [DW-1:0] data;
    logic [1:0]    ack;
    logic          busy;
    logic          err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    per_tx_handshake #(
        .DATA_W        (DW),
        .FIFO_DEPTH    (DEPTH),
        .SYNC_STAGES   (SS),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clkPER    (clk),
        .rstPER    (rst_n),
        .inWrData  (wr_data),
        .inWrLast  (wr_last),
        .inWrValid (wr_valid),
        .outWrReady(wr_ready),
        .outSend   (send),
        .outData   (data),
        .inAck     (ack),
        .outBusy   (busy),
        .outErr    (err)
    );

    typedef struct {
        logic          v;
        logic [DW-1:0] d;
        logic          l;
        logic [1:0]    a;
        logic [1:0]    e_send;
        logic [DW-1:0] e_data;
        logic          e_rdy;
        logic          e_busy;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic v, input logic [DW-1:0] d,
                       input logic l, input logic [1:0] a,
                       input logic [1:0] es, input logic [DW-1:0] ed,
                       input logic er, input logic eb);
        vec_t r;
        r.v = v; r.d = d; r.l = l; r.a = a;
        r.e_send = es; r.e_data = ed; r.e_rdy = er; r.e_busy = eb;
        tbl.push_back(r);
    endtask

    task automatic wait_send(input logic want_active, input string name);
        int n = 0;
        while (((send != 2'b00) != want_active) && n < 40) begin
            step();
            n++;
        end
        chk(name, 32'((send != 2'b00) == want_active), 32'd1);
    endtask

    task automatic deliver(input logic [DW-1:0] d, input logic l);
        wait_send(1'b1, "deliver_rise");
        chk("deliver_data", 32'(data), 32'(d));
        chk("deliver_code", 32'(send), l ? 32'd2 : 32'd1);
        ack = 2'b01;
        wait_send(1'b0, "deliver_drop");
        ack = 2'b00;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((busy || send != 2'b00) && n < 40) begin
            step();
            n++;
        end
        chk(name, 32'(busy), 32'd0);
    endtask

    // Random-phase scoreboard state
    logic [DW:0]   exp_q[$];
    logic [DW:0]   cur;
    logic [1:0]    prev_send;
    logic [DW-1:0] prev_data;
    bit            last_retry;
    int            dly;
    int            accepted;
    int            delivered;
    bit            acc;
    bit            rise;

    initial begin
        rst_n    = 1'b0;
        wr_data  = '0;
        wr_last  = 1'b0;
        wr_valid = 1'b0;
        ack      = 2'b00;
        #12;
        chk("rst_send", 32'(send), 32'd0);
        chk("rst_data", 32'(data), 32'd0);
        chk("rst_ready", 32'(wr_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Single word, ack=11 glitch, then a retry round
        add(1, 16'hA5A5, 1, 2'b00, 2'b00, 16'h0000, 1, 1);
        add(0, 16'h0000, 0, 2'b00, 2'b10, 16'hA5A5, 1, 1);
        add(0, 16'h0000, 0, 2'b01, 2'b10, 16'hA5A5, 1, 1);
        add(0, 16'h0000, 0, 2'b01, 2'b10, 16'hA5A5, 1, 1);
        add(0, 16'h0000, 0, 2'b01, 2'b00, 16'hA5A5, 1, 1);
        add(0, 16'h0000, 0, 2'b00, 2'b00, 16'hA5A5, 1, 1);
        add(0, 16'h0000, 0, 2'b00, 2'b00, 16'hA5A5, 1, 1);
        add(0, 16'h0000, 0, 2'b00, 2'b00, 16'hA5A5, 1, 0);
        add(1, 16'h1234, 0, 2'b00, 2'b00, 16'hA5A5, 1, 1);
        add(0, 16'h0000, 0, 2'b00, 2'b01, 16'h1234, 1, 1);
        for (int i = 0; i < 4; i++) begin
            add(0, 16'h0000, 0, 2'b11, 2'b01, 16'h1234, 1, 1);
        end
        add(0, 16'h0000, 0, 2'b00, 2'b01, 16'h1234, 1, 1);
        add(0, 16'h0000, 0, 2'b10, 2'b01, 16'h1234, 1, 1);
        add(0, 16'h0000, 0, 2'b10, 2'b01, 16'h1234, 1, 1);
        add(0, 16'h0000, 0, 2'b10, 2'b00, 16'h1234, 1, 1);
        add(0, 16'h0000, 0, 2'b00, 2'b00, 16'h1234, 1, 1);
        add(0, 16'h0000, 0, 2'b00, 2'b00, 16'h1234, 1, 1);
        add(0, 16'h0000, 0, 2'b00, 2'b01, 16'h1234, 1, 1);
        add(0, 16'h0000, 0, 2'b01, 2'b01, 16'h1234, 1, 1);
        add(0, 16'h0000, 0, 2'b01, 2'b01, 16'h1234, 1, 1);
        add(0, 16'h0000, 0, 2'b01, 2'b00, 16'h1234, 1, 1);
        add(0, 16'h0000, 0, 2'b00, 2'b00, 16'h1234, 1, 1);
        add(0, 16'h0000, 0, 2'b00, 2'b00, 16'h1234, 1, 1);
        add(0, 16'h0000, 0, 2'b00, 2'b00, 16'h1234, 1, 0);

        foreach (tbl[i]) begin
            wr_valid = tbl[i].v;
            wr_data  = tbl[i].d;
            wr_last  = tbl[i].l;
            ack      = tbl[i].a;
            step();
            chk($sformatf("vec%0d_send", i), 32'(send), 32'(tbl[i].e_send));
            chk($sformatf("vec%0d_data", i), 32'(data), 32'(tbl[i].e_data));
            chk($sformatf("vec%0d_rdy", i), 32'(wr_ready), 32'(tbl[i].e_rdy));
            chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(tbl[i].e_busy));
        end
        chk("vec_err", 32'(err), 32'd0);

        // Fill: one word in flight plus four buffered, sixth dropped
        for (int i = 1; i <= 5; i++) begin
            wr_valid = 1'b1;
            wr_data  = 16'(i);
            wr_last  = (i == 5);
            step();
        end
        chk("fill_full", 32'(wr_ready), 32'd0);
        wr_data = 16'h0006;
        wr_last = 1'b0;
        step();
        wr_valid = 1'b0;
        chk("fill_still_full", 32'(wr_ready), 32'd0);
        chk("fill_head", 32'(data), 32'd1);
        for (int i = 1; i <= 5; i++) begin
            deliver(16'(i), i == 5);
        end
        wait_idle("fill_drained");
        repeat (5) step();
        chk("fill_no_sixth", 32'(send), 32'd0);

        // Reset while a word is being offered
        wr_valid = 1'b1;
        wr_data  = 16'hBEEF;
        wr_last  = 1'b0;
        step();
        wr_valid = 1'b0;
        step();
        chk("rst_mid_pre", 32'(send), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_send", 32'(send), 32'd0);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) step();
        chk("rst_mid_after", 32'(send), 32'd0);
        chk("rst_mid_ready", 32'(wr_ready), 32'd1);
        chk("rst_mid_idle", 32'(busy), 32'd0);

        // Ack changing between clock edges still needs the sync delay
        wr_valid = 1'b1;
        wr_data  = 16'h5A5A;
        wr_last  = 1'b1;
        step();
        wr_valid = 1'b0;
        step();
        chk("async_pre", 32'(send), 32'd2);
        #3;
        ack = 2'b01;
        step();
        chk("async_e1", 32'(send), 32'd2);
        step();
        chk("async_e2", 32'(send), 32'd2);
        step();
        chk("async_e3", 32'(send), 32'd0);
        ack = 2'b00;
        wait_idle("async_idle");

        // Randomized traffic against a CPU-side agent
        last_retry = 1'b0;
        dly        = 0;
        accepted   = 0;
        delivered  = 0;
        prev_send  = send;
        prev_data  = data;
        for (int c = 0; c < 3000; c++) begin
            wr_valid = (c < 2500) && ($urandom_range(0, 2) == 0);
            wr_data  = 16'($urandom);
            wr_last  = 1'($urandom);
            if (ack == 2'b00) begin
                if (send != 2'b00) begin
                    if (dly == 0) begin
                        last_retry = ($urandom_range(0, 3) == 0);
                        ack = last_retry ? 2'b10 : 2'b01;
                        dly = $urandom_range(0, 2);
                    end else begin
                        dly--;
                    end
                end
            end else if (send == 2'b00) begin
                if (dly == 0) begin
                    ack = 2'b00;
                    dly = $urandom_range(0, 3);
                end else begin
                    dly--;
                end
            end
            acc = wr_valid && (exp_q.size() < DEPTH);
            step();
            rise = (prev_send == 2'b00) && (send != 2'b00);
            if (rise) begin
                if (!last_retry) begin
                    if (exp_q.size() == 0) begin
                        chk("rnd_pop_empty", 32'd1, 32'd0);
                    end else begin
                        cur = exp_q.pop_front();
                        delivered++;
                    end
                end
                chk("rnd_data", 32'(data), 32'(cur[DW-1:0]));
                chk("rnd_code", 32'(send), cur[DW] ? 32'd2 : 32'd1);
            end else begin
                chk("rnd_stable", 32'(data), 32'(prev_data));
            end
            if (acc) begin
                exp_q.push_back({wr_last, wr_data});
                accepted++;
            end
            chk("rnd_ready", 32'(wr_ready), 32'(exp_q.size() < DEPTH));
            chk("rnd_legal", 32'(send == 2'b11), 32'd0);
            prev_send = send;
            prev_data = data;
        end
        chk("rnd_drained", 32'(exp_q.size()), 32'd0);
        chk("rnd_count", 32'(delivered), 32'(accepted));
        wait_idle("rnd_idle");

`ifdef PER_TX_TIMEOUT_EN
        begin
            int n = 0;
            ack      = 2'b00;
            wr_valid = 1'b1;
            wr_data  = 16'h0C0C;
            wr_last  = 1'b0;
            step();
            wr_data  = 16'h0D0D;
            wr_last  = 1'b1;
            step();
            wr_valid = 1'b0;
            chk("tmo_offer", 32'(data), 32'h0C0C);
            while (send != 2'b00 && n < 40) begin
                step();
                n++;
            end
            chk("tmo_cycles", 32'(n), 32'(TMO));
            chk("tmo_err", 32'(err), 32'd1);
            deliver(16'h0D0D, 1'b1);
            wait_idle("tmo_idle");
            chk("tmo_err_sticky", 32'(err), 32'd1);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
